writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 191 +++++++++++++++++++
 tb/tb_writeback_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results, a 2-entry formatted-load FIFO and a load scoreboard.
// Optional combinational bypass outputs (byp_valid/byp_rd/byp_data) when WB_BYPASS_EN is defined.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        RegWrite
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data
`endif
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  wb_entry_t        ent0_q, ent0_d;
  wb_entry_t        ent1_q, ent1_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [RW-1:0]    wr_reg_q, wr_reg_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;

  logic             ld_accept;
  wb_entry_t        ld_ent;
  logic             sel_valid;
  logic             sel_is_ld;
  wb_entry_t        sel_ent;
  logic             push;
  logic             pop;

  // RV32I load formatting; unlisted funct3 encodings behave as LW
  function automatic logic [DW-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [DW-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'h0, b};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign ld_ready  = !rst && (state_q != FULL);
  assign ld_accept = ld_valid && ld_ready;
  assign ld_ent    = '{rd: ld_rd, data: fmt_load(ld_funct3, ld_addr_lo, ld_word)};

  assign stall = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);

  // Result selection: ALU, then FIFO head, then a load arriving into an empty FIFO
  always_comb begin
    sel_valid = 1'b0;
    sel_is_ld = 1'b0;
    sel_ent   = '0;
    pop       = 1'b0;
    push      = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_ent   = '{rd: alu_rd, data: alu_data};
      push      = ld_accept;
    end else if (state_q != EMPTY) begin
      sel_valid = 1'b1;
      sel_is_ld = 1'b1;
      sel_ent   = ent0_q;
      pop       = 1'b1;
      push      = ld_accept;
    end else if (ld_accept) begin
      sel_valid = 1'b1;
      sel_is_ld = 1'b1;
      sel_ent   = ld_ent;
    end
  end

  // Occupancy FSM and FIFO storage; entry 0 is always the head
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          ent0_d  = ld_ent;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          ent0_d = ld_ent;
        end else if (push) begin
          ent1_d  = ld_ent;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          ent0_d  = ent1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Scoreboard: a new issue to the same rd overrides the clear from a load write
  always_comb begin
    busy_d = busy_q;
    if (sel_valid && sel_is_ld && (sel_ent.rd != '0)) begin
      busy_d[sel_ent.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = sel_valid && (sel_ent.rd != '0);
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (sel_valid) begin
      wr_reg_d  = sel_ent.rd;
      wr_data_d = sel_ent.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      ent0_q    <= '0;
      ent1_q    <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign RegWrite   = wr_en_q;
  assign write_reg  = wr_reg_q;
  assign write_data = wr_data_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = sel_valid && (sel_ent.rd != '0);
  assign byp_rd    = sel_ent.rd;
  assign byp_data  = sel_ent.data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors push expected writes, a forked monitor pops them.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        RegWrite;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_word    (ld_word),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .stall      (stall),
    .write_reg  (write_reg),
    .write_data (write_data),
    .RegWrite   (RegWrite)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid  (byp_valid),
    .byp_rd     (byp_rd),
    .byp_data   (byp_data)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    ld_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] w);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_word    = w;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{rd: rd, data: d});
  endtask

  // Single directed load written straight through the empty FIFO
  task automatic ld_vec(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] res);
    drive_ld(rd, f3, lo, 32'h80FF7F01);
    if (rd != 5'd0) expect_wr(rd, res);
    cyc();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_word = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;

    fork
      forever begin
        @(negedge clk);
        if (RegWrite === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got x%0d=%0h, expected no write", write_reg, write_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("writeback", 64'({write_reg, write_data}), 64'({mon_e.rd, mon_e.data}));
          end
        end
      end
    join_none

    cyc();
    cyc();
    chk("rst_ld_ready", 64'(ld_ready), 64'(0));
    chk("rst_regwrite", 64'(RegWrite), 64'(0));
    chk("rst_write_reg", 64'(write_reg), 64'(0));
    chk("rst_write_data", 64'(write_data), 64'(0));
    rst = 1'b0;
    #1;
    chk("ld_ready_after_rst", 64'(ld_ready), 64'(1));

    // Load formatting on word 0x80FF7F01
    ld_vec(5'd5,  3'b000, 2'd2, 32'hFFFFFFFF);
    ld_vec(5'd6,  3'b101, 2'd3, 32'h000080FF);
    ld_vec(5'd8,  3'b001, 2'd1, 32'h00007F01);
    ld_vec(5'd10, 3'b010, 2'd0, 32'h80FF7F01);
    ld_vec(5'd0,  3'b010, 2'd0, 32'h0);
    ld_vec(5'd11, 3'b100, 2'd3, 32'h00000080);
    ld_vec(5'd12, 3'b011, 2'd1, 32'h80FF7F01);
    ld_vec(5'd13, 3'b001, 2'd2, 32'hFFFF80FF);
    ld_vec(5'd14, 3'b000, 2'd1, 32'h0000007F);
    ld_vec(5'd15, 3'b110, 2'd0, 32'h80FF7F01);
    idle();
    cyc();
    cyc();
    chk("hold_regwrite", 64'(RegWrite), 64'(0));
    chk("hold_write_reg", 64'(write_reg), 64'(15));
    chk("hold_write_data", 64'(write_data), 64'(32'h80FF7F01));
    drain("drain_formats");

    // ALU/load collision: load is buffered one cycle
    drive_alu(5'd3, 32'h11);
    drive_ld(5'd4, 3'b010, 2'd0, 32'h12345678);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd4, 32'h12345678);
    cyc();
    idle();
    chk("collision_ready_one", 64'(ld_ready), 64'(1));
    drain("drain_collision");

    // ALU held three cycles: FIFO fills, third load refused
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(18 + i), 32'(32'hA1 + i));
      drive_ld(5'(21 + i), 3'b010, 2'd0, 32'(32'hB1 + i));
      expect_wr(5'(18 + i), 32'(32'hA1 + i));
      #1;
      chk("full_ld_ready", 64'(ld_ready), 64'(i < 2 ? 1 : 0));
      cyc();
    end
    idle();
    expect_wr(5'd21, 32'hB1);
    expect_wr(5'd22, 32'hB2);
    drain("drain_full");

    // Simultaneous pop and push with one entry buffered
    drive_alu(5'd28, 32'h28);
    drive_ld(5'd26, 3'b010, 2'd0, 32'h2626);
    expect_wr(5'd28, 32'h28);
    expect_wr(5'd26, 32'h2626);
    cyc();
    alu_valid = 1'b0;
    drive_ld(5'd27, 3'b010, 2'd0, 32'h2727);
    expect_wr(5'd27, 32'h2727);
    #1;
    chk("popush_ready", 64'(ld_ready), 64'(1));
    cyc();
    idle();
    drain("drain_popush");

    // Scoreboard: busy set one edge after issue, cleared on the load write edge
    rs1 = 5'd7;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    #1;
    chk("stall_before_issue_edge", 64'(stall), 64'(0));
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("stall_x7_set", 64'(stall), 64'(1));
    cyc();
    drive_ld(5'd7, 3'b010, 2'd0, 32'h77);
    expect_wr(5'd7, 32'h77);
    #1;
    chk("stall_x7_pending", 64'(stall), 64'(1));
    cyc();
    idle();
    chk("stall_x7_cleared", 64'(stall), 64'(0));
    issue_valid = 1'b1;
    issue_rd = 5'd15;
    cyc();
    idle();
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    chk("stall_rs_zero", 64'(stall), 64'(0));
    rs2 = 5'd15;
    #1;
    chk("stall_rs2_busy", 64'(stall), 64'(1));
    drive_ld(5'd15, 3'b010, 2'd0, 32'h15);
    issue_valid = 1'b1;
    issue_rd = 5'd15;
    expect_wr(5'd15, 32'h15);
    cyc();
    idle();
    chk("stall_set_wins", 64'(stall), 64'(1));
    drive_ld(5'd15, 3'b010, 2'd0, 32'h1515);
    expect_wr(5'd15, 32'h1515);
    cyc();
    idle();
    chk("stall_x15_cleared", 64'(stall), 64'(0));
    drive_ld(5'd0, 3'b010, 2'd0, 32'hDEAD);
    cyc();
    idle();
    chk("rd0_no_regwrite", 64'(RegWrite), 64'(0));
    drain("drain_scoreboard");

    // Reset with FIFO full and x9 busy discards buffered loads
    rs2 = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    cyc();
    issue_valid = 1'b0;
    drive_alu(5'd24, 32'h24);
    drive_ld(5'd9, 3'b010, 2'd0, 32'h99);
    expect_wr(5'd24, 32'h24);
    cyc();
    drive_alu(5'd25, 32'h25);
    drive_ld(5'd17, 3'b010, 2'd0, 32'h1717);
    expect_wr(5'd25, 32'h25);
    cyc();
    idle();
    rs1 = 5'd9;
    #1;
    chk("full_ready_low", 64'(ld_ready), 64'(0));
    chk("stall_x9_before_rst", 64'(stall), 64'(1));
    rst = 1'b1;
    #1;
    chk("ld_ready_in_rst", 64'(ld_ready), 64'(0));
    cyc();
    chk("rst2_regwrite", 64'(RegWrite), 64'(0));
    chk("rst2_write_reg", 64'(write_reg), 64'(0));
    chk("rst2_write_data", 64'(write_data), 64'(0));
    chk("rst2_stall", 64'(stall), 64'(0));
    cyc();
    rst = 1'b0;
    #1;
    chk("rst2_ld_ready", 64'(ld_ready), 64'(1));
    for (int i = 0; i < 5; i++) cyc();
    chk("rst2_no_write", 64'(RegWrite), 64'(0));
    drain("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
